// File: rtl/serial_parity_checker_if.sv
// Bit-stream and result bundle between a serial parity source and serial_parity_checker.
interface serial_parity_checker_if #(
  parameter int unsigned FRAME_LEN = 8
);
  logic                 start;
  logic                 bit_in;
  logic                 bit_valid;
  logic                 busy;
  logic                 frame_done;
  logic                 parity_err;
  logic [FRAME_LEN-1:0] frame_data;
  logic [7:0]           err_count;

  modport master (
    output start, bit_in, bit_valid,
    input  busy, frame_done, parity_err, frame_data, err_count
  );

  modport slave (
    input  start, bit_in, bit_valid,
    output busy, frame_done, parity_err, frame_data, err_count
  );
endinterface

// File: rtl/serial_parity_checker.sv
// Serial frame collector with trailing-parity check for the XOR cell's out1 stream.
// Optional saturating error counter enabled by the PARITY_ERR_COUNT_EN macro.
module serial_parity_checker #(
  parameter int unsigned FRAME_LEN  = 8,
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned ODD_PARITY = 0
) (
  input logic                    clk,
  input logic                    rst_n,
  serial_parity_checker_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    REPORT = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
  localparam logic             ODD_BIT  = (ODD_PARITY != 0);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 acc_q, acc_d;
  logic [FRAME_LEN-1:0] shreg_q, shreg_d;
  logic [FRAME_LEN-1:0] frame_data_q, frame_data_d;
  logic                 parity_err_q, parity_err_d;
  logic                 busy_q, busy_d;
  logic                 frame_done_q, frame_done_d;
  logic                 err_now_s;

  assign err_now_s = acc_q ^ bus.bit_in ^ ODD_BIT;

  // Next-state and datapath; status outputs are derived from the next state so they stay registered.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    shreg_d      = shreg_q;
    frame_data_d = frame_data_q;
    parity_err_d = parity_err_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = DATA;
          cnt_d   = '0;
          acc_d   = 1'b0;
          shreg_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (bus.bit_valid) begin
          acc_d   = acc_q ^ bus.bit_in;
          shreg_d = {shreg_q[FRAME_LEN-2:0], bus.bit_in};
          if (cnt_q == LAST_CNT) begin
            // Counter parks at zero instead of stepping past the last index.
            cnt_d   = '0;
            state_d = PARITY;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
        if (bus.bit_valid) begin
          parity_err_d = err_now_s;
          frame_data_d = shreg_q;
          state_d      = REPORT;
        end else begin
          state_d = PARITY;
        end
      end
      REPORT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d       = (state_d != IDLE);
    frame_done_d = (state_d == REPORT);
  end

  // FSM, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      acc_q        <= 1'b0;
      shreg_q      <= '0;
      frame_data_q <= '0;
      parity_err_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      shreg_q      <= shreg_d;
      frame_data_q <= frame_data_d;
      parity_err_q <= parity_err_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef PARITY_ERR_COUNT_EN
  logic [7:0] err_count_q, err_count_d;
  logic       err_inc_s;

  assign err_inc_s = (state_q == PARITY) && bus.bit_valid && err_now_s;

  // Saturating error tally; cleared only by reset.
  always_comb begin
    if (err_inc_s && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end else begin
      err_count_d = err_count_q;
    end
  end

  // Error counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count_q <= 8'd0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign bus.err_count = err_count_q;
`else
  assign bus.err_count = 8'd0;
`endif

  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_data = frame_data_q;

endmodule

// File: tb/tb_serial_parity_checker.sv
// Self-checking bench: an even-parity and an odd-parity checker see the same bit stream.
module tb_serial_parity_checker;

  logic clk = 1'b0;
  logic rst_n, start, bit_in, bit_valid;
  int   checks = 0;
  int   errors = 0;
  int   done_pulses = 0;
  int   exp_cnt_e = 0;
  int   exp_cnt_o = 0;

  always #5 clk = ~clk;

  serial_parity_checker_if #(.FRAME_LEN(8)) bus_e ();
  serial_parity_checker_if #(.FRAME_LEN(8)) bus_o ();

  assign bus_e.start = start;
  assign bus_e.bit_in = bit_in;
  assign bus_e.bit_valid = bit_valid;
  assign bus_o.start = start;
  assign bus_o.bit_in = bit_in;
  assign bus_o.bit_valid = bit_valid;

  serial_parity_checker #(.FRAME_LEN(8), .CNT_W(4), .ODD_PARITY(0)) dut_even (
    .clk(clk), .rst_n(rst_n), .bus(bus_e));
  serial_parity_checker #(.FRAME_LEN(8), .CNT_W(4), .ODD_PARITY(1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .bus(bus_o));

  always @(negedge clk) if (bus_e.frame_done === 1'b1) done_pulses++;

  typedef struct {
    logic [7:0] data;
    logic       par;
    int         stall_at;
    int         stall_len;
    bit         hold;
    logic       err_e;
    logic       err_o;
    int         lat;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_count(input int n);
`ifdef PARITY_ERR_COUNT_EN
    return (n > 255) ? 8'd255 : 8'(n);
`else
    return (n >= 0) ? 8'd0 : 8'd0;
`endif
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_cnt_e = 0;
    exp_cnt_o = 0;
  endtask

  task automatic run_frame(input vec_t v, input bit rnd);
    bit qb[$];
    bit qv[$];
    int n;
    int lat_exp;
    bit seen;
    for (int i = 0; i < 8; i++) begin
      if (!rnd && i == v.stall_at) begin
        for (int s = 0; s < v.stall_len; s++) begin qb.push_back(1'($urandom)); qv.push_back(1'b0); end
      end
      if (rnd && $urandom_range(3) == 0) begin
        repeat ($urandom_range(2, 1)) begin qb.push_back(1'($urandom)); qv.push_back(1'b0); end
      end
      qb.push_back(v.data[7-i]);
      qv.push_back(1'b1);
    end
    qb.push_back(v.par);
    qv.push_back(1'b1);
    lat_exp = (v.lat >= 0) ? v.lat : qb.size() + 1;
    // Noise in IDLE must be ignored.
    repeat (2) begin
      @(negedge clk);
      start = 1'b0; bit_valid = 1'b1; bit_in = 1'($urandom);
    end
    @(negedge clk);
    start = 1'b1; bit_valid = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      if (n == 1) check("busy_in_frame", 32'(bus_e.busy), 32'd1);
      if (bus_e.frame_done === 1'b1) begin
        seen = 1'b1;
        bit_valid = 1'b0;
      end else begin
        if (!v.hold) start = 1'b0;
        if (n - 1 < qb.size()) begin
          bit_in = qb[n-1]; bit_valid = qv[n-1];
        end else begin
          bit_in = 1'($urandom); bit_valid = 1'b0;
        end
      end
    end
    check("frame_seen", 32'(seen), 32'd1);
    if (v.err_e) exp_cnt_e++;
    if (v.err_o) exp_cnt_o++;
    if (seen) begin
      check("latency", 32'(n), 32'(lat_exp));
      check("done_odd", 32'(bus_o.frame_done), 32'd1);
      check("perr_even", 32'(bus_e.parity_err), 32'(v.err_e));
      check("perr_odd", 32'(bus_o.parity_err), 32'(v.err_o));
      check("fdata_even", 32'(bus_e.frame_data), 32'(v.data));
      check("fdata_odd", 32'(bus_o.frame_data), 32'(v.data));
      check("errcnt_even", 32'(bus_e.err_count), 32'(exp_count(exp_cnt_e)));
      check("errcnt_odd", 32'(bus_o.err_count), 32'(exp_count(exp_cnt_o)));
      @(negedge clk);
      check("done_pulse_end", 32'(bus_e.frame_done), 32'd0);
      check("busy_idle", 32'(bus_e.busy), 32'd0);
      if (v.hold) begin
        @(negedge clk);
        check("restart_first_idle", 32'(bus_e.busy), 32'd1);
        start = 1'b0;
        do_reset();
      end else begin
        start = 1'b0;
      end
    end
  endtask

  initial begin
    vec_t r;
    int snap;
    rst_n = 1'b0; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
    //            data    par  st len hold err_e err_o lat
    vecs[0] = '{8'hB2, 1'b0, -1, 0, 1'b0, 1'b0, 1'b1, 10};
    vecs[1] = '{8'hFF, 1'b1, -1, 0, 1'b0, 1'b1, 1'b0, 10};
    vecs[2] = '{8'h01, 1'b1,  4, 3, 1'b0, 1'b0, 1'b1, 13};
    vecs[3] = '{8'h00, 1'b1, -1, 0, 1'b1, 1'b1, 1'b0, 10};

    // Reset state
    do_reset();
    check("rst_busy", 32'(bus_e.busy), 32'd0);
    check("rst_done", 32'(bus_e.frame_done), 32'd0);
    check("rst_perr", 32'(bus_e.parity_err), 32'd0);
    check("rst_fdata", 32'(bus_e.frame_data), 32'd0);
    check("rst_errcnt", 32'(bus_e.err_count), 32'd0);
    check("rst_busy_odd", 32'(bus_o.busy), 32'd0);

    for (int i = 0; i < 4; i++) run_frame(vecs[i], 1'b0);

    // Mid-frame reset discards the partial frame
    @(posedge clk);
    snap = done_pulses;
    @(negedge clk);
    start = 1'b1; bit_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = 1'b0; bit_valid = 1'b1; bit_in = 1'($urandom);
    end
    do_reset();
    check("midrst_busy", 32'(bus_e.busy), 32'd0);
    run_frame(vecs[0], 1'b0);
    @(posedge clk);
    check("midrst_one_done", 32'(done_pulses - snap), 32'd1);

    // Randomized frames against the frame-level parity rule
    for (int k = 0; k < 30; k++) begin
      r.data = 8'($urandom);
      r.par = 1'($urandom);
      r.stall_at = -1;
      r.stall_len = 0;
      r.hold = 1'b0;
      r.err_e = ^{r.data, r.par};
      r.err_o = ~(^{r.data, r.par});
      r.lat = -1;
      run_frame(r, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
